// File: rtl/fir_coef_pkg.sv
// Shared types and field positions for the FIR coefficient load controller.
package fir_coef_pkg;

   typedef enum logic [1:0] {
      OP_WRITE  = 2'b00,
      OP_COMMIT = 2'b01,
      OP_CLEAR  = 2'b10,
      OP_NOP    = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      CLEAR,
      COMMIT_WAIT,
      ACK
   } state_e;

   localparam int TOG_BIT = 31;
   localparam int OP_HI   = 30;
   localparam int OP_LO   = 29;
   localparam int ADDR_HI = 28;
   localparam int ADDR_LO = 24;
   localparam int CMD_ADDR_W = ADDR_HI - ADDR_LO + 1;

   localparam int ST_ACK    = 31;
   localparam int ST_BUSY   = 30;
   localparam int ST_BANK   = 29;
   localparam int ST_OVR    = 28;
   localparam int ST_ERR_HI = 27;
   localparam int ST_ERR_LO = 20;

   typedef struct packed {
      op_e                   op;
      logic [CMD_ADDR_W-1:0] addr;
   } cmd_t;

   function automatic logic addr_in_range(input logic [CMD_ADDR_W-1:0] a, input int n);
      return int'(a) < n;
   endfunction

endpackage

// File: rtl/fir_coef_cmd_sync.sv
// Qualifies the software toggle (two equal samples), tracks the last accepted
// toggle, holds one pending command seen while busy and flags overruns.
module fir_coef_cmd_sync
   import fir_coef_pkg::*;
(
   input  logic        user_clk,
   input  logic        user_rst,
   input  logic [31:0] cmd_word,
   input  logic        idle,
   output logic        accept_pulse,
   output logic        last_tog,
   output logic        overrun,
   output cmd_t        cmd_lat
);

   logic tog_s1;
   logic pend;
   logic tog_edge;
   logic unused_rsvd;

   assign unused_rsvd = ^cmd_word[ADDR_LO-1:0];
   assign tog_edge    = cmd_word[TOG_BIT] != tog_s1;

   // pend remembers a toggle seen while busy, even if a second toggle
   // restored the original level before the controller became idle again.
   assign accept_pulse = idle && !tog_edge && ((tog_s1 != last_tog) || pend);

   always_ff @(posedge user_clk) begin
      if (user_rst) begin
         tog_s1   <= 1'b0;
         last_tog <= 1'b0;
         pend     <= 1'b0;
         overrun  <= 1'b0;
         cmd_lat  <= '{op: OP_NOP, addr: '0};
      end else begin
         tog_s1 <= cmd_word[TOG_BIT];
         if (accept_pulse) begin
            last_tog <= tog_s1;
            pend     <= 1'b0;
            cmd_lat  <= '{op: op_e'(cmd_word[OP_HI:OP_LO]), addr: cmd_word[ADDR_HI:ADDR_LO]};
         end else if (!idle && tog_edge) begin
            pend <= 1'b1;
            if (pend) overrun <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/fir_coef_load_ctrl.sv
// Coefficient load sequencer: writes tap pairs or clears the shadow bank and
// swaps banks on frame sync, with toggle/ack handshake to PPC software.
module fir_coef_load_ctrl
   import fir_coef_pkg::*;
#(
   parameter int N_PAIRS = 16,
   parameter int ADDR_W  = 4,
   parameter int COEF_W  = 16
) (
   input  logic              user_clk,
   input  logic              user_rst,
   input  logic [31:0]       cmd_word,
   input  logic [31:0]       data_word,
   input  logic              sync_in,
   output logic              coef_we,
   output logic              coef_bank,
   output logic [ADDR_W-1:0] coef_addr,
   output logic [COEF_W-1:0] coef_b0,
   output logic [COEF_W-1:0] coef_b1,
   output logic              active_bank,
   output logic [31:0]       status_word
);

   state_e                state, state_nx;
   logic                  accept, last_tog, overrun;
   cmd_t                  cmd_lat;
   op_e                   op_now;
   logic [CMD_ADDR_W-1:0] addr_now;

   logic                  we_d, bank_flip, err_inc;
   logic [ADDR_W-1:0]     addr_d;
   logic [COEF_W-1:0]     b0_d, b1_d;
   logic                  ack_tog, busy;
   logic [7:0]            err_cnt;

   fir_coef_cmd_sync u_cmd_sync (
      .user_clk     (user_clk),
      .user_rst     (user_rst),
      .cmd_word     (cmd_word),
      .idle         (state == IDLE),
      .accept_pulse (accept),
      .last_tog     (last_tog),
      .overrun      (overrun),
      .cmd_lat      (cmd_lat)
   );

   assign op_now   = op_e'(cmd_word[OP_HI:OP_LO]);
   assign addr_now = cmd_word[ADDR_HI:ADDR_LO];

   // Strobe registers load from the live command on the accept cycle so the
   // write lands on the very next cycle; the latch serves the later states.
   always_comb begin
      state_nx  = state;
      we_d      = 1'b0;
      addr_d    = coef_addr;
      b0_d      = coef_b0;
      b1_d      = coef_b1;
      bank_flip = 1'b0;
      err_inc   = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               case (op_now)
                  OP_WRITE: begin
                     state_nx = WRITE;
                     if (addr_in_range(addr_now, N_PAIRS)) begin
                        we_d   = 1'b1;
                        addr_d = addr_now[ADDR_W-1:0];
                        b0_d   = data_word[0 +: COEF_W];
                        b1_d   = data_word[16 +: COEF_W];
                     end
                  end
                  OP_CLEAR: begin
                     state_nx = CLEAR;
                     we_d     = 1'b1;
                     addr_d   = '0;
                     b0_d     = '0;
                     b1_d     = '0;
                  end
                  OP_COMMIT: state_nx = COMMIT_WAIT;
                  default:   state_nx = ACK;
               endcase
            end
         end
         WRITE: begin
            err_inc  = (cmd_lat.op == OP_WRITE) && !addr_in_range(cmd_lat.addr, N_PAIRS);
            state_nx = ACK;
         end
         CLEAR: begin
            if (coef_addr == ADDR_W'(N_PAIRS - 1)) begin
               state_nx = ACK;
            end else begin
               we_d   = 1'b1;
               addr_d = coef_addr + 1'b1;
            end
         end
         COMMIT_WAIT: begin
            if (sync_in) begin
               bank_flip = 1'b1;
               state_nx  = ACK;
            end
         end
         ACK:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge user_clk) begin
      if (user_rst) begin
         state       <= IDLE;
         coef_we     <= 1'b0;
         coef_addr   <= '0;
         coef_b0     <= '0;
         coef_b1     <= '0;
         active_bank <= 1'b0;
         ack_tog     <= 1'b0;
         busy        <= 1'b0;
         err_cnt     <= 8'd0;
      end else begin
         state     <= state_nx;
         coef_we   <= we_d;
         coef_addr <= addr_d;
         coef_b0   <= b0_d;
         coef_b1   <= b1_d;
         if (bank_flip) active_bank <= ~active_bank;
         if (accept) busy <= 1'b1;
         if (state == ACK) begin
            busy    <= 1'b0;
            ack_tog <= last_tog;
         end
         if (err_inc && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
      end
   end

   // The shadow bank is by construction the one the FIR is not reading.
   assign coef_bank = ~active_bank;

   always_comb begin
      status_word                      = '0;
      status_word[ST_ACK]              = ack_tog;
      status_word[ST_BUSY]             = busy;
      status_word[ST_BANK]             = active_bank;
      status_word[ST_OVR]              = overrun;
      status_word[ST_ERR_HI:ST_ERR_LO] = err_cnt;
   end

endmodule
